// File: rtl/gtxe2_chnl_pkg.sv
// rtl/gtxe2_chnl_pkg.sv - shared constants for the GTXE2 channel model
// Purpose: 8b/10b K28.5 comma patterns in word bit order (bit0 = first bit on
//          the line, 8b/10b bit a). These are shared by the transmit side, the
//          receive path and the benches.
// Ports:   none (package)
package gtxe2_chnl_pkg;

   localparam int         comma_len = 10;
   localparam logic [9:0] k28_5_rdm = 10'h17c;
   localparam logic [9:0] k28_5_rdp = 10'h283;

endpackage

// File: rtl/gtxe2_chnl_rx_comma_det.sv
// rtl/gtxe2_chnl_rx_comma_det.sv - 10-bit K28.5 window comparator
// Purpose: flags a 10-bit window that equals either comma pattern.
//          Purely combinational; also used by the receive byte-align model.
// Ports:   win  in  10  candidate window, bit0 = earliest received bit
//          hit  out 1   window equals comma_p or comma_m
module gtxe2_chnl_rx_comma_det
   import gtxe2_chnl_pkg::*;
#(
   parameter logic [9:0] comma_p = k28_5_rdm,
   parameter logic [9:0] comma_m = k28_5_rdp
) (
   input  logic [9:0] win,
   output logic       hit
);

   assign hit = (win == comma_p) || (win == comma_m);

endmodule

// File: rtl/gtxe2_chnl_rx_des.sv
// rtl/gtxe2_chnl_rx_des.sv - 1:width serial deserializer with comma alignment
// Purpose: assembles width-bit words from one line bit per clk (LSB first),
//          realigns word boundaries to K28.5 and strobes each finished word.
// Ports:   clk       in   1      serial bit clock
//          reset     in   1      asynchronous active-high reset
//          indata    in   1      serial line bit
//          idle_in   in   1      line idle flag for this bit
//          outdata   out  width  assembled word, bit0 = earliest bit
//          outvalid  out  1      one-cycle word strobe
//          idle_out  out  1      every bit of the word was idle
//          comma_out out  1      outdata[9:0] is a comma
//          realign   out  1      one-cycle pulse: boundary moved
//          aligned   out  1      comma seen on the current boundary
module gtxe2_chnl_rx_des
   import gtxe2_chnl_pkg::*;
#(
   parameter int         width    = 20,
   parameter logic [9:0] comma_p  = k28_5_rdm,
   parameter logic [9:0] comma_m  = k28_5_rdp,
   parameter bit         align_en = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             indata,
   input  logic             idle_in,
   output logic [width-1:0] outdata,
   output logic             outvalid,
   output logic             idle_out,
   output logic             comma_out,
   output logic             realign,
   output logic             aligned
);

   localparam int            cw          = $clog2(width);
   localparam logic [cw-1:0] cnt_last    = cw'(width - 1);
   localparam logic [cw-1:0] cnt_comma   = cw'(comma_len - 1);
   localparam logic [cw-1:0] cnt_realign = cw'(comma_len % width);

   // Bit 0 of the shift registers would only ever be shifted out, never read,
   // so the history is kept as [width-1:1]; the incoming bit completes a word.
   logic [width-1:1] shreg;
   logic [width-1:1] idlesh;
   logic [cw-1:0]    cnt;

   logic [width-1:0] word;
   logic [width-1:0] idle_word;
   logic             hit;
   logic             word_hit;
   logic             misalign;

   assign word      = {indata, shreg};
   assign idle_word = {idle_in, idlesh};

   // Last ten bits including the one arriving now.
   gtxe2_chnl_rx_comma_det #(
      .comma_p (comma_p),
      .comma_m (comma_m)
   ) u_win_det (
      .win (word[width-1:width-10]),
      .hit (hit)
   );

   // Comma flag for the low ten bits of a completing word.
   gtxe2_chnl_rx_comma_det #(
      .comma_p (comma_p),
      .comma_m (comma_m)
   ) u_word_det (
      .win (word[9:0]),
      .hit (word_hit)
   );

   assign misalign = align_en && hit && (cnt != cnt_comma);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg     <= '0;
         idlesh    <= '0;
         cnt       <= '0;
         outdata   <= '0;
         outvalid  <= 1'b0;
         idle_out  <= 1'b0;
         comma_out <= 1'b0;
         realign   <= 1'b0;
         aligned   <= 1'b0;
      end else begin
         shreg  <= word[width-1:1];
         idlesh <= idle_word[width-1:1];
         if (misalign) begin
            // The comma just received becomes bits 0..9 of a new word; the
            // partial word in progress is dropped, even if it was complete.
            cnt      <= cnt_realign;
            realign  <= 1'b1;
            aligned  <= 1'b0;
            outvalid <= 1'b0;
         end else begin
            realign <= 1'b0;
            if (hit && (cnt == cnt_comma)) begin
               aligned <= 1'b1;
            end
            if (cnt == cnt_last) begin
               cnt       <= '0;
               outdata   <= word;
               idle_out  <= &idle_word;
               comma_out <= word_hit;
               outvalid  <= 1'b1;
            end else begin
               cnt      <= cnt + 1'b1;
               outvalid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_gtxe2_chnl_rx_des.sv
// tb/tb_gtxe2_chnl_rx_des.sv - bench for gtxe2_chnl_rx_des (width 20, align on/off)
module tb_gtxe2_chnl_rx_des;
   import gtxe2_chnl_pkg::*;

   localparam int W = 20;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic indata = 1'b0;
   logic idle_in = 1'b0;

   logic [1:0][W-1:0] od;
   logic [1:0]        ov, io, co, ra, al;

   always #5 clk = ~clk;

   // Instance 0 realigns on commas, instance 1 keeps free-running boundaries.
   gtxe2_chnl_rx_des #(.width(W), .align_en(1'b1)) dut (
      .clk(clk), .reset(reset), .indata(indata), .idle_in(idle_in),
      .outdata(od[0]), .outvalid(ov[0]), .idle_out(io[0]),
      .comma_out(co[0]), .realign(ra[0]), .aligned(al[0])
   );

   gtxe2_chnl_rx_des #(.width(W), .align_en(1'b0)) dut_na (
      .clk(clk), .reset(reset), .indata(indata), .idle_in(idle_in),
      .outdata(od[1]), .outvalid(ov[1]), .idle_out(io[1]),
      .comma_out(co[1]), .realign(ra[1]), .aligned(al[1])
   );

   int n_chk = 0;
   int n_pass = 0;
   int edge_n = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   // Each instance fills the word one bit position at a time; a misaligned
   // comma makes those ten comma bits the first ten bits of a fresh word.
   logic [9:0]   h10, ih10;
   int           mpos [2];
   logic [W-1:0] mw [2];
   logic [W-1:0] mi [2];
   logic [W-1:0] e_d [2];
   logic         e_v [2], e_i [2], e_c [2], e_r [2], e_a [2];

   function automatic bit is_k(input logic [9:0] v);
      return (v == k28_5_rdm) || (v == k28_5_rdp);
   endfunction

   task automatic model_reset();
      h10 = '0;
      ih10 = '0;
      for (int m = 0; m < 2; m++) begin
         mpos[m] = 0; mw[m] = '0; mi[m] = '0; e_d[m] = '0;
         e_v[m] = 0; e_i[m] = 0; e_c[m] = 0; e_r[m] = 0; e_a[m] = 0;
      end
   endtask

   task automatic model_step(input logic b, input logic idl);
      h10  = {b, h10[9:1]};
      ih10 = {idl, ih10[9:1]};
      for (int m = 0; m < 2; m++) begin
         if (is_k(h10) && mpos[m] != 9 && m == 0) begin
            mw[m][9:0] = h10;
            mi[m][9:0] = ih10;
            mpos[m] = 10;
            e_r[m] = 1; e_a[m] = 0; e_v[m] = 0;
         end else begin
            e_r[m] = 0;
            if (is_k(h10) && mpos[m] == 9) e_a[m] = 1;
            mw[m][mpos[m]] = b;
            mi[m][mpos[m]] = idl;
            if (mpos[m] == W - 1) begin
               e_v[m] = 1;
               e_d[m] = mw[m];
               e_i[m] = &mi[m];
               e_c[m] = is_k(mw[m][9:0]);
               mpos[m] = 0;
            end else begin
               e_v[m] = 0;
               mpos[m]++;
            end
         end
      end
   endtask

   // ---------------- observation logs ----------------
   int           sv_edge [$];
   logic [W-1:0] sv_data [$];
   logic         sv_idle [$];
   logic         sv_comma [$];
   int           rl_edge [$];
   int           na_edge [$];
   logic [W-1:0] na_data [$];
   logic         na_idle [$];
   int           na_rl;

   task automatic clear_logs();
      sv_edge.delete(); sv_data.delete(); sv_idle.delete(); sv_comma.delete();
      rl_edge.delete(); na_edge.delete(); na_data.delete(); na_idle.delete();
      na_rl = 0;
   endtask

   task automatic compare_now();
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("cycle inst%0d edge %0d", m, edge_n - 1),
             {od[m], ov[m], io[m], co[m], ra[m], al[m]},
             {e_d[m], e_v[m], e_i[m], e_c[m], e_r[m], e_a[m]});
      end
      if (ov[0]) begin
         sv_edge.push_back(edge_n - 1); sv_data.push_back(od[0]);
         sv_idle.push_back(io[0]); sv_comma.push_back(co[0]);
      end
      if (ra[0]) rl_edge.push_back(edge_n - 1);
      if (ov[1]) begin
         na_edge.push_back(edge_n - 1); na_data.push_back(od[1]); na_idle.push_back(io[1]);
      end
      if (ra[1]) na_rl++;
   endtask

   task automatic send_bit(input logic b, input logic idl);
      @(negedge clk);
      compare_now();
      indata = b;
      idle_in = idl;
      model_step(b, idl);
      edge_n++;
   endtask

   task automatic send_word(input logic [W-1:0] w, input int nbits);
      for (int i = 0; i < nbits; i++) send_bit(w[i], 1'b0);
   endtask

   task automatic flush();
      @(negedge clk);
      compare_now();
   endtask

   // Reset is raised between edges and the outputs are checked before any edge.
   task automatic do_reset(input string tag);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      for (int m = 0; m < 2; m++)
         chk($sformatf("%s reset zero inst%0d", tag, m),
             {od[m], ov[m], io[m], co[m], ra[m], al[m]}, 64'd0);
      model_reset();
      clear_logs();
      @(posedge clk);
      #2 reset = 1'b0;
      indata = 1'b0;
      idle_in = 1'b0;
      edge_n = 0;
   endtask

   logic [W-1:0] wc, wd, wp;
   logic [9:0]   junk;

   initial begin
      wc = 20'h5817c;
      wd = 20'hABCDE;
      wp = 20'hFFE83;
      junk = 10'h155;
      model_reset();
      clear_logs();
      #23;

      // Pre-aligned stream, then a partial word that the next reset discards.
      do_reset("s1");
      send_word(wc, W); send_word(wd, W); send_word(wc, W);
      send_word(wd, 7);
      flush();
      chk("s1 realign count", rl_edge.size(), 0);
      chk("s1 strobe count", sv_data.size(), 3);
      if (sv_data.size() >= 3) begin
         chk("s1 first strobe edge", sv_edge[0], 19);
         chk("s1 word0", sv_data[0], 20'h5817c);
         chk("s1 comma0", sv_comma[0], 1);
         chk("s1 word1", sv_data[1], 20'hABCDE);
         chk("s1 comma1", sv_comma[1], 0);
         chk("s1 spacing", sv_edge[2] - sv_edge[1], 20);
      end
      chk("s1 aligned", al[0], 1);

      // Misaligned by 7 bits: reset mid-word, then realign on the comma.
      do_reset("s2");
      for (int i = 0; i < 7; i++) send_bit(junk[i], 1'b0);
      send_word(wc, W); send_word(wd, W); send_word(wc, W);
      flush();
      chk("s2 realign count", rl_edge.size(), 1);
      if (rl_edge.size() >= 1) chk("s2 realign edge", rl_edge[0], 16);
      chk("s2 strobe count", sv_data.size(), 3);
      if (sv_data.size() >= 3) begin
         chk("s2 strobe edge0", sv_edge[0], 26);
         chk("s2 word0", sv_data[0], 20'h5817c);
         chk("s2 comma0", sv_comma[0], 1);
         chk("s2 word1", sv_data[1], 20'hABCDE);
         chk("s2 strobe edge2", sv_edge[2], 66);
      end
      chk("s2 noalign realign count", na_rl, 0);
      if (na_data.size() >= 1) begin
         chk("s2 noalign edge0", na_edge[0], 19);
         chk("s2 noalign word0", na_data[0], 20'h0BE55);
      end else chk("s2 noalign strobe count", na_data.size(), 3);

      // Comma ends exactly at the last bit of a word: that word is dropped.
      do_reset("s3");
      for (int i = 0; i < 10; i++) send_bit(junk[i], 1'b0);
      send_word(wc, W); send_word(wd, W);
      flush();
      chk("s3 realign count", rl_edge.size(), 1);
      if (rl_edge.size() >= 1) chk("s3 realign edge", rl_edge[0], 19);
      chk("s3 strobe count", sv_data.size(), 2);
      if (sv_data.size() >= 2) begin
         chk("s3 strobe edge0", sv_edge[0], 29);
         chk("s3 word0", sv_data[0], 20'h5817c);
         chk("s3 word1", sv_data[1], 20'hABCDE);
      end

      // RD+ comma on the word boundary.
      do_reset("s4");
      send_word(wp, W);
      flush();
      chk("s4 strobe count", sv_data.size(), 1);
      if (sv_data.size() >= 1) begin
         chk("s4 word0", sv_data[0], 20'hFFE83);
         chk("s4 comma0", sv_comma[0], 1);
      end
      chk("s4 aligned", al[0], 1);
      chk("s4 noalign aligned", al[1], 1);
      chk("s4 realign count", rl_edge.size(), 0);

      // Idle: one fully idle word, then a word with one active bit.
      do_reset("s5");
      for (int i = 0; i < W; i++) send_bit(1'b0, 1'b1);
      for (int i = 0; i < W; i++) send_bit(1'b0, (i != 5));
      flush();
      chk("s5 strobe count", sv_idle.size(), 2);
      if (sv_idle.size() >= 2) begin
         chk("s5 idle word0", sv_idle[0], 1);
         chk("s5 idle word1", sv_idle[1], 0);
      end
      if (na_idle.size() >= 2) chk("s5 noalign idle word0", na_idle[0], 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
